// File: rtl/test_result_monitor.sv
// End-of-test checker on the core retire side: decides pass / fail / timeout and raises halt.
// Optional tohost store detection is compiled in with `define TESTMON_TOHOST_EN.
module test_result_monitor #(
   parameter logic [31:0] END_PC        = 32'h0000_0044,
   parameter int          TIMEOUT_TICKS = 5000,
   parameter int          CNT_W         = 32,
   parameter logic [31:0] TOHOST_ADDR   = 32'h0000_1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             retire_valid,
   input  logic [31:0]      retire_pc,
   input  logic [31:0]      gp_value,
`ifdef TESTMON_TOHOST_EN
   input  logic             st_valid,
   input  logic [31:0]      st_addr,
   input  logic [31:0]      st_data,
`endif
   output logic             running,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic             halt,
   output logic [30:0]      fail_test,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] retired_count
);

   // state    | meaning
   // S_IDLE   | out of reset, waiting for start
   // S_RUN    | test running, counters advancing
   // S_PASS   | end event with code 1 (sticky)
   // S_FAIL   | end event with other code (sticky)
   // S_TMO    | cycle budget exhausted (sticky)
   typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TMO} state_t;

   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TIMEOUT_TICKS - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
   logic [CNT_W-1:0] retired_count_q, retired_count_d;
   logic [30:0]      fail_test_q, fail_test_d;
   logic             running_q, done_q, pass_q, fail_q, timeout_q;

   logic        pc_end, tohost_end, end_event, end_pass, timeout_hit;
   logic [30:0] end_code;

   always_comb begin
      pc_end     = retire_valid && (retire_pc == END_PC);
`ifdef TESTMON_TOHOST_EN
      tohost_end = st_valid && (st_addr == TOHOST_ADDR) && st_data[0];
`else
      tohost_end = 1'b0;
`endif
      end_event  = pc_end || tohost_end;
      // PC rule takes priority over a same-cycle tohost store
      if (pc_end) begin
         end_pass = (gp_value == 32'd1);
         end_code = gp_value[31:1];
      end else begin
`ifdef TESTMON_TOHOST_EN
         end_pass = (st_data == 32'd1);
         end_code = st_data[31:1];
`else
         end_pass = 1'b0;
         end_code = 31'd0;
`endif
      end
      timeout_hit = (TIMEOUT_TICKS != 0) && (cycle_count_q == TICK_LAST);

      state_d         = state_q;
      cycle_count_d   = cycle_count_q;
      retired_count_d = retired_count_q;
      fail_test_d     = fail_test_q;

      case (state_q)
         S_RUN: begin
            if (cycle_count_q != '1) cycle_count_d = cycle_count_q + 1'b1;
            if (retire_valid && (retired_count_q != '1))
               retired_count_d = retired_count_q + 1'b1;
            if (end_event) begin
               if (end_pass) begin
                  state_d = S_PASS;
               end else begin
                  state_d     = S_FAIL;
                  fail_test_d = end_code;
               end
            end else if (timeout_hit) begin
               state_d = S_TMO;
            end
         end
         default: begin
            if (start) begin
               state_d         = S_RUN;
               cycle_count_d   = '0;
               retired_count_d = '0;
               fail_test_d     = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q         <= S_IDLE;
         cycle_count_q   <= '0;
         retired_count_q <= '0;
         fail_test_q     <= '0;
         running_q       <= 1'b0;
         done_q          <= 1'b0;
         pass_q          <= 1'b0;
         fail_q          <= 1'b0;
         timeout_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         cycle_count_q   <= cycle_count_d;
         retired_count_q <= retired_count_d;
         fail_test_q     <= fail_test_d;
         running_q       <= (state_d == S_RUN);
         done_q          <= (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TMO);
         pass_q          <= (state_d == S_PASS);
         fail_q          <= (state_d == S_FAIL);
         timeout_q       <= (state_d == S_TMO);
      end
   end

   assign running       = running_q;
   assign done          = done_q;
   assign halt          = done_q;
   assign pass          = pass_q;
   assign fail          = fail_q;
   assign timeout       = timeout_q;
   assign fail_test     = fail_test_q;
   assign cycle_count   = cycle_count_q;
   assign retired_count = retired_count_q;

endmodule

// File: tb/tb_test_result_monitor.sv
// Directed table-driven bench for test_result_monitor plus hand sequences for timeout,
// end-on-timeout, reset-vs-start and (when compiled in) the tohost rule.
module tb_test_result_monitor;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        retire_valid = 1'b0;
   logic [31:0] retire_pc = '0;
   logic [31:0] gp_value = '0;
   logic        st_valid = 1'b0;
   logic [31:0] st_addr = '0;
   logic [31:0] st_data = '0;
   logic        running, done, pass, fail, timeout, halt;
   logic [30:0] fail_test;
   logic [31:0] cycle_count, retired_count;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   test_result_monitor dut (
      .clk(clk), .rst(rst), .start(start), .retire_valid(retire_valid),
      .retire_pc(retire_pc), .gp_value(gp_value),
`ifdef TESTMON_TOHOST_EN
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
`endif
      .running(running), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
      .halt(halt), .fail_test(fail_test), .cycle_count(cycle_count),
      .retired_count(retired_count)
   );

   // flags = {running, done, halt, pass, fail, timeout}
   localparam logic [5:0] F_IDLE = 6'b000000;
   localparam logic [5:0] F_RUN  = 6'b100000;
   localparam logic [5:0] F_PASS = 6'b011100;
   localparam logic [5:0] F_FAIL = 6'b011010;
   localparam logic [5:0] F_TMO  = 6'b011001;

   typedef struct packed {
      logic        start;
      logic        rv;
      logic [31:0] pc;
      logic [31:0] gp;
      logic [5:0]  flags;
      logic [30:0] ft;
      logic [31:0] cyc;
      logic [31:0] ret;
   } vec_t;

   vec_t vecs [22];

   function automatic logic [100:0] observed();
      return {running, done, halt, pass, fail, timeout, fail_test, cycle_count, retired_count};
   endfunction

   task automatic check(input string name, input logic [100:0] got, input logic [100:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic rv, input logic [31:0] pc, input logic [31:0] gp);
      start = s; retire_valid = rv; retire_pc = pc; gp_value = gp;
   endtask

   task automatic drive_st(input logic v, input logic [31:0] a, input logic [31:0] d);
      st_valid = v; st_addr = a; st_data = d;
   endtask

   initial begin
      int n;
      bit seen;

      vecs[0] = '{1'b1, 1'b0, 32'h0, 32'h0, F_RUN, 31'd0, 32'd0, 32'd0};
      for (int i = 1; i <= 10; i++)
         vecs[i] = '{1'b0, 1'b1, 32'h10 + 32'(4*i), 32'h0, F_RUN, 31'd0, 32'(i), 32'(i)};
      vecs[11] = '{1'b0, 1'b1, 32'h44, 32'h1, F_PASS, 31'd0, 32'd11, 32'd11};
      vecs[12] = '{1'b0, 1'b0, 32'h0,  32'h0, F_PASS, 31'd0, 32'd11, 32'd11};
      vecs[13] = '{1'b1, 1'b0, 32'h0,  32'h0, F_RUN,  31'd0, 32'd0,  32'd0};
      vecs[14] = '{1'b0, 1'b1, 32'h44, 32'h7, F_FAIL, 31'd3, 32'd1,  32'd1};
      vecs[15] = '{1'b1, 1'b0, 32'h0,  32'h0, F_RUN,  31'd0, 32'd0,  32'd0};
      vecs[16] = '{1'b1, 1'b0, 32'h0,  32'h0, F_RUN,  31'd0, 32'd1,  32'd0};
      vecs[17] = '{1'b0, 1'b0, 32'h44, 32'h1, F_RUN,  31'd0, 32'd2,  32'd0};
      vecs[18] = '{1'b0, 1'b1, 32'h44, 32'h0, F_FAIL, 31'd0, 32'd3,  32'd1};
      vecs[19] = '{1'b0, 1'b1, 32'h44, 32'h1, F_FAIL, 31'd0, 32'd3,  32'd1};
      vecs[20] = '{1'b1, 1'b0, 32'h0,  32'h0, F_RUN,  31'd0, 32'd0,  32'd0};
      vecs[21] = '{1'b0, 1'b1, 32'h44, 32'hFFFF_FFFF, F_FAIL, 31'h7FFF_FFFF, 32'd1, 32'd1};

      // reset
      rst = 1'b0;
      step();
      check("reset", observed(), '0);
      rst = 1'b1;
      step();
      check("idle_after_reset", observed(), '0);

      foreach (vecs[i]) begin
         drive(vecs[i].start, vecs[i].rv, vecs[i].pc, vecs[i].gp);
         step();
         check($sformatf("vec%0d", i), observed(),
               {vecs[i].flags, vecs[i].ft, vecs[i].cyc, vecs[i].ret});
      end
      drive(0, 0, 0, 0);

      // timeout exactly 5000 cycles after entering RUN
      drive(1, 0, 0, 0);
      step();
      drive(0, 0, 0, 0);
      n = 0; seen = 0;
      while (n < 6000 && !seen) begin
         step();
         n++;
         if (timeout) seen = 1;
      end
      check("timeout_latency", 101'(n), 101'd5000);
      check("timeout_state", observed(), {F_TMO, 31'd0, 32'd5000, 32'd0});

      // END_PC pass on the timeout cycle wins
      drive(1, 0, 0, 0);
      step();
      drive(0, 0, 0, 0);
      repeat (4999) step();
      check("pre_timeout", observed(), {F_RUN, 31'd0, 32'd4999, 32'd0});
      drive(0, 1, 32'h44, 32'h1);
      step();
      drive(0, 0, 0, 0);
      check("end_beats_timeout", observed(), {F_PASS, 31'd0, 32'd5000, 32'd1});
      drive(1, 0, 0, 0);
      step();
      drive(0, 0, 0, 0);
      check("restart_after_pass", observed(), {F_RUN, 31'd0, 32'd0, 32'd0});

      // reset wins over start
      rst = 1'b0; start = 1'b1;
      step();
      check("reset_beats_start", observed(), '0);
      rst = 1'b1; start = 1'b0;
      step();
      check("idle_hold", observed(), '0);

`ifdef TESTMON_TOHOST_EN
      drive(1, 0, 0, 0);
      step();
      drive(0, 0, 0, 0);
      drive_st(1, 32'h1004, 32'h1);
      step();
      check("tohost_wrong_addr", observed(), {F_RUN, 31'd0, 32'd1, 32'd0});
      drive_st(1, 32'h1000, 32'h4);
      step();
      check("tohost_bit0_clear", observed(), {F_RUN, 31'd0, 32'd2, 32'd0});
      drive_st(1, 32'h1000, 32'h5);
      step();
      drive_st(0, 0, 0);
      check("tohost_fail", observed(), {F_FAIL, 31'd2, 32'd3, 32'd0});
      drive(1, 0, 0, 0);
      step();
      drive(0, 0, 0, 0);
      drive_st(1, 32'h1000, 32'h1);
      step();
      drive_st(0, 0, 0);
      check("tohost_pass", observed(), {F_PASS, 31'd0, 32'd1, 32'd0});
      drive(1, 0, 0, 0);
      step();
      drive(0, 1, 32'h44, 32'h1);
      drive_st(1, 32'h1000, 32'h5);
      step();
      drive(0, 0, 0, 0);
      drive_st(0, 0, 0);
      check("pc_beats_tohost", observed(), {F_PASS, 31'd0, 32'd1, 32'd1});
`else
      // st_* are not ports in this build; a store must not end the test
      drive(1, 0, 0, 0);
      step();
      drive(0, 0, 0, 0);
      drive_st(1, 32'h1000, 32'h5);
      step();
      drive_st(0, 0, 0);
      check("no_tohost_rule", observed(), {F_RUN, 31'd0, 32'd1, 32'd0});
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
